// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: funct3 encodings shared with the load path, store FSM states and error codes
package riscv_mem_pkg;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3 = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_READ, S_WRITE} state_t;
endpackage

// File: rtl/store_unit_if.sv
// store_unit_if: core request/completion and single-word memory port of the store unit
interface store_unit_if #(
  parameter int AW = 32
);
  logic req_valid;
  logic req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0] req_data;
  logic [2:0] req_funct3;
  logic done;
  logic [1:0] err_code;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_wstrb;
  logic mem_we;
  logic mem_re;
  logic [31:0] mem_rdata;
  logic mem_ready;
  modport slave (
    input req_valid, req_addr, req_data, req_funct3, mem_rdata, mem_ready,
    output req_ready, done, err_code, mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re
  );
  modport master (
    output req_valid, req_addr, req_data, req_funct3, mem_rdata, mem_ready,
    input req_ready, done, err_code, mem_addr, mem_wdata, mem_wstrb, mem_we, mem_re
  );
endinterface

// File: rtl/store_align.sv
// store_align: places SB/SH/SW data on its byte lanes and flags natural-alignment violations
module store_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned
);
  assign wstrb = funct3 == F3_SB ? 4'b0001 << a :
                 funct3 == F3_SH ? 4'b0011 << a :
                 funct3 == F3_SW ? 4'b1111 : 4'b0000;
  assign wdata = funct3 == F3_SB ? {24'b0, data[7:0]} << {a, 3'b000} :
                 funct3 == F3_SH ? {16'b0, data[15:0]} << {a, 3'b000} :
                 funct3 == F3_SW ? data : 32'b0;
  assign misaligned = (funct3 == F3_SH && a[0]) || (funct3 == F3_SW && a != 2'b00);
endmodule

// File: rtl/store_unit.sv
// store_unit: RISC-V SB/SH/SW store path with lane alignment, strobes and wait timeout
// STORE_RMW_EN: memory lacks byte enables, SB/SH become read-merge-write
module store_unit
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT = 255
) (
  input logic clk,
  input logic reset,
  store_unit_if.slave bus
);
`ifdef STORE_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, state_nx;
  logic [1:0] a_q;
  logic [31:0] data_q;
  logic [2:0] f3_q;
  logic [CW-1:0] wait_cnt;
  logic done_q, done_nx;
  logic [1:0] err_q, err_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic [31:0] al_wdata;
  logic [3:0] al_wstrb;
  logic al_mis, bad_f3, busy, tmo;
  logic [31:0] lane_mask;
  store_align u_align (
    .a(a_q),
    .funct3(f3_q),
    .data(data_q),
    .wdata(al_wdata),
    .wstrb(al_wstrb),
    .misaligned(al_mis)
  );
  assign bad_f3 = f3_q > F3_SW;
  assign busy = state == S_READ || state == S_WRITE;
  // the stall that would make the count reach MAX_WAIT aborts instead
  assign tmo = busy && !bus.mem_ready && wait_cnt == CW'(MAX_WAIT - 1);
  assign lane_mask = {{8{al_wstrb[3]}}, {8{al_wstrb[2]}}, {8{al_wstrb[1]}}, {8{al_wstrb[0]}}};
  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    err_nx = ERR_OK;
    case (state)
      S_IDLE: state_nx = bus.req_valid ? S_CHECK : S_IDLE;
      S_CHECK: begin
        state_nx = (bad_f3 || al_mis) ? S_IDLE : (RMW && f3_q != F3_SW) ? S_READ : S_WRITE;
        done_nx = bad_f3 || al_mis;
        err_nx = bad_f3 ? ERR_FUNCT3 : al_mis ? ERR_MISALIGN : ERR_OK;
      end
      S_READ: begin
        state_nx = bus.mem_ready ? S_WRITE : tmo ? S_IDLE : S_READ;
        done_nx = tmo;
        err_nx = tmo ? ERR_TIMEOUT : ERR_OK;
      end
      S_WRITE: begin
        state_nx = (bus.mem_ready || tmo) ? S_IDLE : S_WRITE;
        done_nx = bus.mem_ready || tmo;
        err_nx = tmo ? ERR_TIMEOUT : ERR_OK;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      wait_cnt <= '0;
      done_q <= 1'b0;
      err_q <= ERR_OK;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      a_q <= '0;
      data_q <= '0;
      f3_q <= '0;
    end else begin
      state <= state_nx;
      done_q <= done_nx;
      err_q <= err_nx;
      wait_cnt <= state_nx != state ? '0 : (busy && !bus.mem_ready) ? wait_cnt + 1'b1 : wait_cnt;
      if (state == S_IDLE && bus.req_valid) begin
        addr_q <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
        a_q <= bus.req_addr[1:0];
        data_q <= bus.req_data;
        f3_q <= bus.req_funct3;
      end
      if (state == S_CHECK) begin
        wdata_q <= al_wdata;
        wstrb_q <= RMW ? 4'b1111 : al_wstrb;
      end
      if (state == S_READ && bus.mem_ready) wdata_q <= (bus.mem_rdata & ~lane_mask) | al_wdata;
    end
  end
  assign bus.req_ready = state == S_IDLE;
  assign bus.done = done_q;
  assign bus.err_code = err_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_we = state == S_WRITE;
  assign bus.mem_re = RMW && state == S_READ;
endmodule
